muldiv_unit: RTL

//   Iterative HI/LO multiply/divide unit beside the EXE stage of the 5-stage MIPS pipeline.
//   EXE issues MULT/MULTU/DIV/DIVU with forwarded rs/rt operands; the unit runs radix-2 for

---
 rtl/muldiv_unit.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit: radix-2 shift-add multiply and restoring divide,
// WIDTH iterations plus a sign-correction/commit cycle; busy stalls the pipeline meanwhile.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

  state_t             state, state_next;
  logic [CW-1:0]      counter;
  logic               is_div;
  logic               neg_q;
  logic               neg_r;
  logic               b_zero;
  logic [WIDTH-1:0]   a_raw;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH:0]     rem;

  logic               in_signed;
  logic               in_a_neg;
  logic               in_b_neg;
  logic [WIDTH-1:0]   in_a_abs;
  logic [WIDTH-1:0]   in_b_abs;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_trial;
  logic [WIDTH+1:0]   div_diff;
  logic [2*WIDTH-1:0] prod_final;
  logic [WIDTH-1:0]   quot_final;
  logic [WIDTH-1:0]   rem_final;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start && !flush) state_next = CALC;
      CALC: begin
        if (flush)              state_next = IDLE;
        else if (counter == '0) state_next = FINISH;
      end
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand magnitudes at issue; op[0]=1 selects the unsigned variants.
  always_comb begin
    in_signed = ~op[0];
    in_a_neg  = in_signed & src_a[WIDTH-1];
    in_b_neg  = in_signed & src_b[WIDTH-1];
    in_a_abs  = in_a_neg ? (~src_a + 1'b1) : src_a;
    in_b_abs  = in_b_neg ? (~src_b + 1'b1) : src_b;
  end

  // Multiply keeps the multiplier in acc's low half; divide keeps the dividend/quotient there.
  always_comb begin
    mul_sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a_mag} : '0);
    div_trial  = {rem[WIDTH-1:0], acc[WIDTH-1]};
    div_diff   = {1'b0, div_trial} - {2'b00, b_mag};
    prod_final = neg_q ? (~acc + 1'b1) : acc;
    quot_final = neg_q ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
    rem_final  = neg_r ? (~rem[WIDTH-1:0] + 1'b1) : rem[WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi      <= '0;
      lo      <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      counter <= '0;
      is_div  <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      b_zero  <= 1'b0;
      a_raw   <= '0;
      a_mag   <= '0;
      b_mag   <= '0;
      acc     <= '0;
      rem     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !flush) begin
            busy    <= 1'b1;
            counter <= CW'(WIDTH - 1);
            is_div  <= op[1];
            neg_q   <= in_a_neg ^ in_b_neg;
            neg_r   <= in_a_neg;
            b_zero  <= (src_b == '0);
            a_raw   <= src_a;
            a_mag   <= in_a_abs;
            b_mag   <= in_b_abs;
            acc     <= {{WIDTH{1'b0}}, (op[1] ? in_a_abs : in_b_abs)};
            rem     <= '0;
          end else begin
            if (mthi) hi <= wdata;
            if (mtlo) lo <= wdata;
          end
        end
        CALC: begin
          if (flush) begin
            busy <= 1'b0;
          end else begin
            counter <= counter - 1'b1;
            if (is_div) begin
              if (!div_diff[WIDTH+1]) begin
                rem <= div_diff[WIDTH:0];
                acc <= {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], 1'b1};
              end else begin
                rem <= div_trial;
                acc <= {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], 1'b0};
              end
            end else begin
              acc <= {mul_sum, acc[WIDTH-1:1]};
            end
          end
        end
        FINISH: begin
          busy <= 1'b0;
          if (!flush) begin
            done <= 1'b1;
            if (!is_div) begin
              {hi, lo} <= prod_final;
            end else if (b_zero) begin
              hi <= a_raw;
              lo <= '1;
            end else begin
              hi <= rem_final;
              lo <= quot_final;
            end
          end
        end
        default: busy <= 1'b0;
      endcase
    end
  end

endmodule
